regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback producers: port A (ALU result) and port B (load data).
- Keeps a 32-bit pending-write scoreboard so decode can stall on RAW hazards.
- Sits between the execute/memory stages and the regfile's RegWrite/WriteAddr/WriteData inputs; its outputs connect directly to those inputs.

---
 rtl/regfile_wb_if.sv | 64 ++++++
 rtl/regfile_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_if
//
// Purpose: bundles every bus signal of regfile_wb_arbiter. That covers the two
// writeback request ports, the decode-side scoreboard query, the register-file
// write port and the debug view of the arbiter state.
//
// Handshake: a request is accepted on a rising edge where valid && ready.
// ready only depends on valid and on arbiter state, never on data. A
// requester holds valid/addr/data stable until it sees ready.
//
// Modports:
//   slave  - the arbiter side. It receives requests and drives ready, stall,
//            the regfile write port, busy and the debug state.
//   master - the environment side (execute/memory stages, decode, regfile).
//
// Signal summary:
//   a_valid/a_addr/a_data/a_ready  ALU writeback request (port A)
//   b_valid/b_addr/b_data/b_ready  load writeback request (port B)
//   issue_valid/issue_addr         decode marks a destination as pending
//   ReadAddr1/ReadAddr2/use1/use2  decode source operands for the hazard check
//   stall                          RAW hazard on a used source
//   RegWrite/WriteAddr/WriteData   register-file write port
//   busy                           pending-write scoreboard
//   dbg_starve_cnt                 starvation counter (0 in round-robin builds)
//   dbg_rr_a                       round-robin pointer, 1 = A preferred next
// ---------------------------------------------------------------------------
interface regfile_wb_if;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [4:0]  ReadAddr1;
    logic [4:0]  ReadAddr2;
    logic        use1;
    logic        use2;
    logic        stall;
    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic [31:0] busy;
    logic [3:0]  dbg_starve_cnt;
    logic        dbg_rr_a;

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  issue_valid, issue_addr, ReadAddr1, ReadAddr2, use1, use2,
        output a_ready, b_ready, stall, RegWrite, WriteAddr, WriteData, busy,
        output dbg_starve_cnt, dbg_rr_a
    );

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output issue_valid, issue_addr, ReadAddr1, ReadAddr2, use1, use2,
        input  a_ready, b_ready, stall, RegWrite, WriteAddr, WriteData, busy,
        input  dbg_starve_cnt, dbg_rr_a
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose: shares the single register-file write port between the ALU
// writeback (port A) and the load writeback (port B). It also keeps a 32-bit
// scoreboard of registers with a write in flight, so decode can stall on
// RAW hazards.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   wb     regfile_wb_if.slave. It carries the request ports, the scoreboard
//          query, the regfile write port and the debug state.
//
// Parameters:
//   STARVE_MAX  number of consecutive lost arbitrations port A may suffer
//               while valid before it is force-granted (1..15).
//
// Configuration macro:
//   WB_RR_EN  when defined, round-robin arbitration replaces the fixed
//             B-over-A priority and the starvation guard. The pointer starts
//             on A and only moves on a contested grant. The counter reads 0.
//
// Timing: an accepted request appears on RegWrite/WriteAddr/WriteData exactly
// one cycle later. A write to r0 is consumed but produces no RegWrite pulse.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input logic        clk,
    input logic        reset,
    regfile_wb_if.slave wb
);

    logic [3:0]  starve_q, starve_d;
    logic        rr_a_q, rr_a_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] busy_q, busy_d;
    logic        grant_a, grant_b;

    // Arbitration. Both grants are held low during reset, so nothing can be
    // accepted on a reset edge.
`ifdef WB_RR_EN
    always_comb begin
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        rr_a_d   = rr_a_q;
        starve_d = '0;
        if (!reset) begin
            if (wb.a_valid && wb.b_valid) begin
                // Contested: serve the preferred port, then hand preference over.
                grant_a = rr_a_q;
                grant_b = !rr_a_q;
                rr_a_d  = !rr_a_q;
            end else begin
                grant_a = wb.a_valid;
                grant_b = wb.b_valid;
            end
        end
    end
`else
    localparam logic [3:0] STARVE_CAP = 4'(STARVE_MAX);
    logic force_a;

    always_comb begin
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        rr_a_d   = rr_a_q;
        starve_d = starve_q;
        force_a  = (starve_q == STARVE_CAP);
        if (!reset) begin
            grant_a = wb.a_valid && (!wb.b_valid || force_a);
            grant_b = wb.b_valid && !grant_a;
        end
        // The counter measures how long A has waited. It restarts once A is
        // served or A stops asking. It saturates so the force stays asserted.
        if (!wb.a_valid || grant_a) begin
            starve_d = '0;
        end else if (!force_a) begin
            starve_d = starve_q + 4'd1;
        end
    end
`endif

    // Output register: loads on accept. When nothing is accepted, the address
    // and data hold their values and RegWrite drops.
    always_comb begin
        reg_write_d = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        if (grant_a) begin
            reg_write_d = (wb.a_addr != 5'd0);
            waddr_d     = wb.a_addr;
            wdata_d     = wb.a_data;
        end else if (grant_b) begin
            reg_write_d = (wb.b_addr != 5'd0);
            waddr_d     = wb.b_addr;
            wdata_d     = wb.b_data;
        end
    end

    // Scoreboard: a bit clears on the edge where the regfile commits it. The
    // set is applied after the clear, so a new issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (reg_write_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (wb.issue_valid && (wb.issue_addr != 5'd0)) begin
            busy_d[wb.issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q    <= '0;
            rr_a_q      <= 1'b1;
            reg_write_q <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            busy_q      <= '0;
        end else begin
            starve_q    <= starve_d;
            rr_a_q      <= rr_a_d;
            reg_write_q <= reg_write_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign wb.a_ready   = grant_a;
    assign wb.b_ready   = grant_b;
    assign wb.RegWrite  = reg_write_q;
    assign wb.WriteAddr = waddr_q;
    assign wb.WriteData = wdata_q;
    assign wb.busy      = busy_q;
    assign wb.stall     = (wb.use1 && (wb.ReadAddr1 != 5'd0) && busy_q[wb.ReadAddr1]) ||
                          (wb.use2 && (wb.ReadAddr2 != 5'd0) && busy_q[wb.ReadAddr2]);
    assign wb.dbg_starve_cnt = starve_q;
    assign wb.dbg_rr_a       = rr_a_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_wb_if wb_if();

    regfile_wb_arbiter #(.STARVE_MAX(3)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb_if.slave)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        wb_if.a_valid = 1'b0; wb_if.a_addr = '0; wb_if.a_data = '0;
        wb_if.b_valid = 1'b0; wb_if.b_addr = '0; wb_if.b_data = '0;
        wb_if.issue_valid = 1'b0; wb_if.issue_addr = '0;
        wb_if.ReadAddr1 = '0; wb_if.ReadAddr2 = '0;
        wb_if.use1 = 1'b0; wb_if.use2 = 1'b0;
    endtask

    task automatic drive_a(input logic v, input logic [4:0] addr, input logic [31:0] data);
        wb_if.a_valid = v; wb_if.a_addr = addr; wb_if.a_data = data;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] addr, input logic [31:0] data);
        wb_if.b_valid = v; wb_if.b_addr = addr; wb_if.b_data = data;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        a_valid;
        logic [4:0]  a_addr;
        logic [31:0] a_data;
        logic        b_valid;
        logic [4:0]  b_addr;
        logic [31:0] b_data;
        logic        exp_a_ready;
        logic        exp_b_ready;
        logic        exp_reg_write;   // after the edge
        logic        chk_wr;          // compare WriteAddr/WriteData after the edge
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_cnt;         // starvation counter after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                           input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                           input logic ear, input logic ebr, input logic erw,
                           input logic cw, input logic [4:0] ewa, input logic [31:0] ewd,
                           input logic [3:0] ecnt);
        vec_t v;
        v.a_valid = av; v.a_addr = aa; v.a_data = ad;
        v.b_valid = bv; v.b_addr = ba; v.b_data = bd;
        v.exp_a_ready = ear; v.exp_b_ready = ebr; v.exp_reg_write = erw;
        v.chk_wr = cw; v.exp_waddr = ewa; v.exp_wdata = ewd; v.exp_cnt = ecnt;
        vecs.push_back(v);
    endtask

    // Contended request pattern: A = r3 / AAAA0003, B = r4 / BBBB0004.
    localparam logic [31:0] DA = 32'hAAAA_0003;
    localparam logic [31:0] DB = 32'hBBBB_0004;

    logic [31:0] exp_busy;

    initial begin
        reset = 1'b1;
        idle_inputs();

        // ---------------- reset check ----------------
        drive_a(1'b1, 5'd1, 32'h1);
        drive_b(1'b1, 5'd2, 32'h2);
        #1;
        chk("reset_a_ready", {31'd0, wb_if.a_ready}, 32'd0);
        chk("reset_b_ready", {31'd0, wb_if.b_ready}, 32'd0);
        step();
        step();
        chk("reset_regwrite", {31'd0, wb_if.RegWrite}, 32'd0);
        chk("reset_busy", wb_if.busy, 32'd0);
        chk("reset_waddr", {27'd0, wb_if.WriteAddr}, 32'd0);
        chk("reset_wdata", wb_if.WriteData, 32'd0);
        chk("reset_cnt", {28'd0, wb_if.dbg_starve_cnt}, 32'd0);
        reset = 1'b0;
        idle_inputs();

        // ---------------- table: single writes + contention ----------------
        //      A valid/addr/data          B valid/addr/data         ar   br   rw  cw  waddr  wdata           cnt
        add_vec(1, 5'd5, 32'hDEADBEEF,    0, 5'd0, 32'h0,            1,   0,   1,  1,  5'd5,  32'hDEADBEEF,   0);
        add_vec(0, 5'd0, 32'h0,           0, 5'd0, 32'h0,            0,   0,   0,  1,  5'd5,  32'hDEADBEEF,   0);
        add_vec(0, 5'd0, 32'h0,           1, 5'd6, 32'h0000_0011,    0,   1,   1,  1,  5'd6,  32'h0000_0011,  0);
`ifdef WB_RR_EN
        // Pointer still on A: contested grants alternate A,B,A,B,A.
        add_vec(1, 5'd3, DA,              1, 5'd4, DB,               1,   0,   1,  1,  5'd3,  DA,             0);
        add_vec(1, 5'd3, DA,              1, 5'd4, DB,               0,   1,   1,  1,  5'd4,  DB,             0);
        add_vec(1, 5'd3, DA,              1, 5'd4, DB,               1,   0,   1,  1,  5'd3,  DA,             0);
        add_vec(1, 5'd3, DA,              1, 5'd4, DB,               0,   1,   1,  1,  5'd4,  DB,             0);
        add_vec(1, 5'd3, DA,              1, 5'd4, DB,               1,   0,   1,  1,  5'd3,  DA,             0);
`else
        // B wins three times, the counter reaches 3, A is forced, then B again.
        add_vec(1, 5'd3, DA,              1, 5'd4, DB,               0,   1,   1,  1,  5'd4,  DB,             1);
        add_vec(1, 5'd3, DA,              1, 5'd4, DB,               0,   1,   1,  1,  5'd4,  DB,             2);
        add_vec(1, 5'd3, DA,              1, 5'd4, DB,               0,   1,   1,  1,  5'd4,  DB,             3);
        add_vec(1, 5'd3, DA,              1, 5'd4, DB,               1,   0,   1,  1,  5'd3,  DA,             0);
        add_vec(1, 5'd3, DA,              1, 5'd4, DB,               0,   1,   1,  1,  5'd4,  DB,             1);
`endif
        // A write to r0 is consumed but produces no RegWrite pulse.
        add_vec(1, 5'd0, 32'h1234_5678,   0, 5'd0, 32'h0,            1,   0,   0,  0,  5'd0,  32'h0,          0);
        add_vec(0, 5'd0, 32'h0,           0, 5'd0, 32'h0,            0,   0,   0,  0,  5'd0,  32'h0,          0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive_a(vecs[i].a_valid, vecs[i].a_addr, vecs[i].a_data);
            drive_b(vecs[i].b_valid, vecs[i].b_addr, vecs[i].b_data);
            #1;
            chk($sformatf("vec%0d_a_ready", i), {31'd0, wb_if.a_ready}, {31'd0, vecs[i].exp_a_ready});
            chk($sformatf("vec%0d_b_ready", i), {31'd0, wb_if.b_ready}, {31'd0, vecs[i].exp_b_ready});
            step();
            chk($sformatf("vec%0d_regwrite", i), {31'd0, wb_if.RegWrite}, {31'd0, vecs[i].exp_reg_write});
            if (vecs[i].chk_wr) begin
                chk($sformatf("vec%0d_waddr", i), {27'd0, wb_if.WriteAddr}, {27'd0, vecs[i].exp_waddr});
                chk($sformatf("vec%0d_wdata", i), wb_if.WriteData, vecs[i].exp_wdata);
            end
            chk($sformatf("vec%0d_cnt", i), {28'd0, wb_if.dbg_starve_cnt}, {28'd0, vecs[i].exp_cnt});
            chk($sformatf("vec%0d_busy", i), wb_if.busy, 32'd0);
        end
        idle_inputs();
        step();

        // ---------------- scoreboard / stall on r7 ----------------
        wb_if.issue_valid = 1'b1; wb_if.issue_addr = 5'd7;
        step();
        wb_if.issue_valid = 1'b0;
        wb_if.use1 = 1'b1; wb_if.ReadAddr1 = 5'd7;
        #1;
        chk("sb7_busy_set", wb_if.busy, 32'h0000_0080);
        chk("sb7_stall", {31'd0, wb_if.stall}, 32'd1);
        wb_if.use1 = 1'b0;
        #1;
        chk("sb7_unused_no_stall", {31'd0, wb_if.stall}, 32'd0);
        wb_if.use2 = 1'b1; wb_if.ReadAddr2 = 5'd7;
        #1;
        chk("sb7_use2_stall", {31'd0, wb_if.stall}, 32'd1);
        wb_if.use2 = 1'b0; wb_if.use1 = 1'b1;
        step();
        chk("sb7_stall_hold", {31'd0, wb_if.stall}, 32'd1);
        drive_a(1'b1, 5'd7, 32'h0000_0777);
        #1;
        chk("sb7_a_ready", {31'd0, wb_if.a_ready}, 32'd1);
        step();
        drive_a(1'b0, 5'd0, 32'd0);
        #1;
        chk("sb7_regwrite", {31'd0, wb_if.RegWrite}, 32'd1);
        chk("sb7_waddr", {27'd0, wb_if.WriteAddr}, 32'd7);
        chk("sb7_stall_commit_cycle", {31'd0, wb_if.stall}, 32'd1);
        step();
        chk("sb7_stall_clear", {31'd0, wb_if.stall}, 32'd0);
        chk("sb7_busy_clear", wb_if.busy, 32'd0);
        idle_inputs();

        // ---------------- same-edge set/clear on r9 ----------------
        wb_if.issue_valid = 1'b1; wb_if.issue_addr = 5'd9;
        step();
        wb_if.issue_valid = 1'b0;
        drive_a(1'b1, 5'd9, 32'h0000_0999);
        step();
        drive_a(1'b0, 5'd0, 32'd0);
        // Commit cycle for r9 coincides with a new issue to r9.
        wb_if.issue_valid = 1'b1; wb_if.issue_addr = 5'd9;
        #1;
        chk("r9_regwrite", {31'd0, wb_if.RegWrite}, 32'd1);
        step();
        wb_if.issue_valid = 1'b0;
        chk("r9_set_wins", wb_if.busy, 32'h0000_0200);
        drive_a(1'b1, 5'd9, 32'h0000_0998);
        step();
        drive_a(1'b0, 5'd0, 32'd0);
        step();
        chk("r9_cleared", wb_if.busy, 32'd0);

        // ---------------- r0 write and issue to r0 ----------------
        exp_busy = 32'h0000_1000;
        wb_if.issue_valid = 1'b1; wb_if.issue_addr = 5'd12;
        step();
        wb_if.issue_addr = 5'd0;   // issue to r0 must never set a bit
        drive_a(1'b1, 5'd0, 32'hFFFF_FFFF);
        #1;
        chk("r0_a_ready", {31'd0, wb_if.a_ready}, 32'd1);
        step();
        wb_if.issue_valid = 1'b0;
        drive_a(1'b0, 5'd0, 32'd0);
        chk("r0_regwrite", {31'd0, wb_if.RegWrite}, 32'd0);
        chk("r0_busy_unchanged", wb_if.busy, exp_busy);
        wb_if.use2 = 1'b1; wb_if.ReadAddr2 = 5'd12;
        #1;
        chk("r12_stall", {31'd0, wb_if.stall}, 32'd1);
        wb_if.use1 = 1'b1; wb_if.ReadAddr1 = 5'd0; wb_if.use2 = 1'b0;
        #1;
        chk("r0_source_no_stall", {31'd0, wb_if.stall}, 32'd0);
        idle_inputs();

        // ---------------- reset mid-operation ----------------
        drive_b(1'b1, 5'd13, 32'h1313_1313);
        step();
        drive_b(1'b0, 5'd0, 32'd0);
        chk("mid_regwrite_before", {31'd0, wb_if.RegWrite}, 32'd1);
        reset = 1'b1;
        drive_a(1'b1, 5'd14, 32'h1414_1414);
        #1;
        chk("mid_a_ready_in_reset", {31'd0, wb_if.a_ready}, 32'd0);
        step();
        chk("mid_regwrite_after", {31'd0, wb_if.RegWrite}, 32'd0);
        chk("mid_busy_lost", wb_if.busy, 32'd0);
        reset = 1'b0;
        idle_inputs();
        step();
        chk("post_reset_idle", {31'd0, wb_if.RegWrite}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
